// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin sharing of the register-file write port between two writeback requesters
module regfile_wb_arbiter #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] dest0,
  input  logic [DATA_W-1:0] val0,
  output logic              ack0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] dest1,
  input  logic [DATA_W-1:0] val1,
  output logic              ack1,
  output logic [ADDR_W-1:0] destReg,
  output logic [DATA_W-1:0] destVal,
  output logic              storeNow,
  input  logic              storeDone,
  output logic              busy,
  output logic              timeout_err
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, STORE, RELEASE} state_t;
  state_t state, stateNxt;
  logic prio, prioNxt, win, winNxt, pick1, expired;
  logic [CW-1:0] cnt, cntNxt;
  logic [ADDR_W-1:0] destRegNxt;
  logic [DATA_W-1:0] destValNxt;
  logic storeNowNxt, ack0Nxt, ack1Nxt, errNxt;
  // a tie goes to port[prio]; a lone requester always wins
  assign pick1 = req1 & (~req0 | prio);
  assign expired = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
  assign busy = state != IDLE;
  always_comb begin
    stateNxt = state;
    prioNxt = prio;
    winNxt = win;
    cntNxt = cnt + 1'b1;
    destRegNxt = destReg;
    destValNxt = destVal;
    storeNowNxt = storeNow;
    ack0Nxt = 1'b0;
    ack1Nxt = 1'b0;
    errNxt = timeout_err;
    case (state)
      IDLE: begin
        cntNxt = '0;
        if (req0 | req1) begin
          stateNxt = STORE;
          winNxt = pick1;
          destRegNxt = pick1 ? dest1 : dest0;
          destValNxt = pick1 ? val1 : val0;
          storeNowNxt = 1'b1;
        end
      end
      STORE: if (storeDone | expired) begin
        stateNxt = RELEASE;
        storeNowNxt = 1'b0;
        prioNxt = ~win;
        cntNxt = '0;
        ack0Nxt = storeDone & ~win;
        ack1Nxt = storeDone & win;
        errNxt = timeout_err | ~storeDone;
      end
      RELEASE: if (~storeDone | expired) begin
        stateNxt = IDLE;
        cntNxt = '0;
        errNxt = timeout_err | storeDone;
      end
      default: stateNxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      prio <= 1'b0;
      win <= 1'b0;
      cnt <= '0;
      destReg <= '0;
      destVal <= '0;
      storeNow <= 1'b0;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= stateNxt;
      prio <= prioNxt;
      win <= winNxt;
      cnt <= cntNxt;
      destReg <= destRegNxt;
      destVal <= destValNxt;
      storeNow <= storeNowNxt;
      ack0 <= ack0Nxt;
      ack1 <= ack1Nxt;
      timeout_err <= errNxt;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed tests against a behavioural arbiter model and a register-file responder
`timescale 1ns/100ps
module tb_regfile_wb_arbiter;
  localparam int TO = 4;
  localparam int LAT = 1;
  typedef struct packed {logic [3:0] d; logic [15:0] v;} wr_t;
  logic clk = 0, rst = 0;
  logic req0 = 0, req1 = 0, ack0, ack1, storeNow, storeDone = 0, busy, timeout_err;
  logic [3:0] dest0 = 0, dest1 = 0, destReg;
  logic [15:0] val0 = 0, val1 = 0, destVal;
  regfile_wb_arbiter #(.DATA_W(16), .ADDR_W(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req0(req0), .dest0(dest0), .val0(val0), .ack0(ack0),
    .req1(req1), .dest1(dest1), .val1(val1), .ack1(ack1), .destReg(destReg),
    .destVal(destVal), .storeNow(storeNow), .storeDone(storeDone), .busy(busy),
    .timeout_err(timeout_err));
  always #5 clk = ~clk;
  int nVec = 0, nBad = 0, nAck0 = 0, nAck1 = 0;
  wr_t q0[$], q1[$];
  int ackOrder[$];
  logic [15:0] r [16];
  bit stuck = 0;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // requesters: each port presents the head of its queue until acked
  initial forever begin
    @(posedge clk); #2;
    if (!rst) begin
      req0 = 0;
      req1 = 0;
    end else begin
      if (ack0 && q0.size() > 0) q0.delete(0);
      if (ack1 && q1.size() > 0) q1.delete(0);
      req0 = q0.size() > 0;
      req1 = q1.size() > 0;
      if (req0) begin dest0 = q0[0].d; val0 = q0[0].v; end
      if (req1) begin dest1 = q1[0].d; val1 = q1[0].v; end
    end
  end
  // register file: answers storeNow after LAT cycles unless stuck
  int hi = 0;
  initial forever begin
    @(posedge clk); #2;
    if (!rst || stuck || !storeNow) begin
      hi = 0;
      storeDone = 0;
    end else if (hi >= LAT) begin
      storeDone = 1;
      r[destReg] = destVal;
    end else hi++;
  end
  logic sRst = 0, sReq0 = 0, sReq1 = 0, sDone = 0;
  logic [3:0] sD0 = 0, sD1 = 0;
  logic [15:0] sV0 = 0, sV1 = 0;
  always @(posedge clk) begin
    sRst = rst; sReq0 = req0; sReq1 = req1; sD0 = dest0; sD1 = dest1;
    sV0 = val0; sV1 = val1; sDone = storeDone;
  end
  // model: phase 0 waiting, 1 write requested, 2 waiting for release; age counts cycles in phase
  int ph = 0, age = 0;
  bit mPrio = 0, mWin = 0, mSn = 0, mErr = 0;
  logic [1:0] mAck = 0;
  logic [3:0] mDest = 0;
  logic [15:0] mVal = 0;
  always @(negedge clk) begin
    if (!rst || !sRst) begin
      ph = 0; age = 0; mPrio = 0; mWin = 0; mSn = 0; mErr = 0; mAck = 0; mDest = 0; mVal = 0;
    end else begin
      mAck = 0;
      if (ph == 0) begin
        if (sReq0 || sReq1) begin
          mWin = (sReq0 && sReq1) ? mPrio : sReq1;
          mDest = mWin ? sD1 : sD0;
          mVal = mWin ? sV1 : sV0;
          mSn = 1; ph = 1; age = 0;
        end
      end else if (ph == 1) begin
        if (sDone || age == TO - 1) begin
          if (sDone) mAck[mWin] = 1; else mErr = 1;
          mSn = 0; mPrio = !mWin; ph = 2; age = 0;
        end else age++;
      end else begin
        if (!sDone) ph = 0;
        else if (age == TO - 1) begin mErr = 1; ph = 0; end
        else age++;
      end
      check("storeNow", storeNow, mSn);
      check("destReg", destReg, mDest);
      check("destVal", destVal, mVal);
      check("ack0", ack0, mAck[0]);
      check("ack1", ack1, mAck[1]);
      check("busy", busy, ph != 0);
      check("timeout_err", timeout_err, mErr);
      check("ack_exclusive", ack0 & ack1, 0);
      if (ack0) begin ackOrder.push_back(0); nAck0++; end
      if (ack1) begin ackOrder.push_back(1); nAck1++; end
    end
  end
  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #3; end
  endtask
  task automatic doReset;
    @(posedge clk); #3;
    rst = 0; q0.delete(); q1.delete(); stuck = 0;
    @(posedge clk); #2;
    rst = 1; #1;
    ackOrder.delete(); nAck0 = 0; nAck1 = 0;
  endtask
  task automatic waitStore;
    int n = 0;
    while (!storeNow && n < 50) begin step(); n++; end
    check("wait_storeNow", storeNow, 1);
  endtask
  task automatic waitIdle;
    int n = 0;
    while ((q0.size() || q1.size() || req0 || req1 || busy) && n < 300) begin step(); n++; end
    check("wait_idle", n < 300, 1);
  endtask
  initial begin
    for (int i = 0; i < 16; i++) r[i] = 0;
    step(3);
    doReset();
    // async reset in the middle of a write
    stuck = 1;
    q0.push_back('{4'd9, 16'hABCD});
    waitStore();
    check("t1_pre_storeNow", storeNow, 1);
    rst = 0; q0.delete(); stuck = 0;
    #1;
    check("t1_storeNow", storeNow, 0);
    check("t1_ack0", ack0, 0);
    check("t1_ack1", ack1, 0);
    check("t1_destReg", destReg, 0);
    check("t1_destVal", destVal, 0);
    check("t1_timeout_err", timeout_err, 0);
    check("t1_busy", busy, 0);
    @(posedge clk); #2; rst = 1; #1;
    // single port 0 write
    q0.push_back('{4'd3, 16'd256});
    waitStore();
    check("t2_destReg", destReg, 3);
    check("t2_destVal", destVal, 256);
    waitIdle();
    check("t2_r3", r[3], 256);
    check("t2_nack0", nAck0, 1);
    check("t2_nack1", nAck1, 0);
    // simultaneous pairs from reset
    doReset();
    q0.push_back('{4'd5, 16'd128});
    q1.push_back('{4'd6, 16'h00FF});
    waitIdle();
    check("t3_count", ackOrder.size(), 2);
    check("t3_first", ackOrder[0], 0);
    check("t3_second", ackOrder[1], 1);
    check("t3_r5", r[5], 128);
    check("t3_r6", r[6], 16'h00FF);
    ackOrder.delete();
    q0.push_back('{4'd11, 16'd7});
    waitIdle();
    q0.push_back('{4'd12, 16'd1});
    q1.push_back('{4'd13, 16'd2});
    waitIdle();
    check("t3b_count", ackOrder.size(), 3);
    check("t3b_pair_first", ackOrder[1], 1);
    check("t3b_pair_second", ackOrder[2], 0);
    check("t3b_r12", r[12], 1);
    check("t3b_r13", r[13], 2);
    // same destination: grant order decides the final value
    doReset();
    q0.push_back('{4'd7, 16'd1});
    q1.push_back('{4'd7, 16'd2});
    waitIdle();
    check("t4_r7", r[7], 2);
    check("t4_count", ackOrder.size(), 2);
    check("t4_first", ackOrder[0], 0);
    check("t4_second", ackOrder[1], 1);
    // port 1 held while port 0 re-requests right after its ack
    doReset();
    q0.push_back('{4'd1, 16'h1111});
    q0.push_back('{4'd2, 16'h2222});
    q1.push_back('{4'd4, 16'h4444});
    q1.push_back('{4'd8, 16'h8888});
    waitIdle();
    check("t6_count", ackOrder.size(), 4);
    check("t6_o0", ackOrder[0], 0);
    check("t6_o1", ackOrder[1], 1);
    check("t6_o2", ackOrder[2], 0);
    check("t6_o3", ackOrder[3], 1);
    check("t6_r2", r[2], 16'h2222);
    check("t6_r8", r[8], 16'h8888);
    // storeDone never rises: guard aborts the write
    doReset();
    stuck = 1;
    q0.push_back('{4'd2, 16'h0055});
    waitStore();
    begin
      int n = 0;
      while (storeNow && n < 20) begin n++; step(); end
      check("t5_store_cycles", n, TO);
    end
    check("t5_err", timeout_err, 1);
    q0.delete();
    step();
    check("t5_idle", busy, 0);
    step(3);
    check("t5_err_sticky", timeout_err, 1);
    check("t5_busy", busy, 0);
    check("t5_no_ack", nAck0 + nAck1, 0);
    stuck = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end
endmodule
